// File: rtl/itch_feed_arbiter_if.sv
// Feed-side, parser-side and status signals of itch_feed_arbiter.
// The slave modport is the arbiter's view and the master modport is the driver's view.
interface itch_feed_arbiter_if #(
  parameter int NUM_FEEDS = 2,
  parameter int CNT_W     = 16
);
  logic [NUM_FEEDS*8-1:0] feed_data_i;
  logic [NUM_FEEDS-1:0]   feed_valid_i;
  logic [NUM_FEEDS-1:0]   feed_ready_o;
  logic [7:0]             data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [NUM_FEEDS-1:0]   grant_o;
  logic                   busy_o;
  logic                   msg_done_o;
  logic                   len_err_o;
  logic [CNT_W-1:0]       msg_count_o;

  modport slave (
    input  feed_data_i, feed_valid_i, ready_i,
    output feed_ready_o, data_o, valid_o, grant_o, busy_o,
           msg_done_o, len_err_o, msg_count_o
  );

  modport master (
    output feed_data_i, feed_valid_i, ready_i,
    input  feed_ready_o, data_o, valid_o, grant_o, busy_o,
           msg_done_o, len_err_o, msg_count_o
  );
endinterface

// File: rtl/itch_feed_arbiter.sv
// Round-robin arbiter that hands the byte-serial ITCH parser to one feed for
// exactly one length-prefixed message at a time.
module itch_feed_arbiter #(
  parameter int NUM_FEEDS   = 2,
  parameter int MAX_MSG_LEN = 64,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  itch_feed_arbiter_if.slave bus
);
  localparam int          IDX_W   = (NUM_FEEDS > 1) ? $clog2(NUM_FEEDS) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_LEN);

  typedef enum logic [1:0] {IDLE, LEN_HI, LEN_LO, BODY} state_t;

  state_t               state_q, state_d;
  logic [NUM_FEEDS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic [15:0]          remaining_q, remaining_d;
  logic [CNT_W-1:0]     msg_count_q, msg_count_d;
  logic                 msg_done_q, msg_done_d;
  logic                 len_err_q, len_err_d;

  logic [7:0]           feed_byte [NUM_FEEDS];
  logic [NUM_FEEDS-1:0] req_rot;
  logic [IDX_W:0]       pick_off;
  logic [IDX_W:0]       pick_sum;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 busy;
  logic                 sel_valid;
  logic                 hs;
  logic                 done;
  logic [15:0]          len_full;

  for (genvar gi = 0; gi < NUM_FEEDS; gi++) begin : g_feed
    assign feed_byte[gi] = bus.feed_data_i[gi*8 +: 8];
  end

  assign busy      = (state_q != IDLE);
  assign sel_valid = busy & bus.feed_valid_i[gidx_q];
  assign hs        = sel_valid & bus.ready_i;
  assign len_full  = {len_hi_q, feed_byte[gidx_q]};

  // grant_q is all-zero in IDLE, so the ready fan-out needs no state gating.
  assign bus.data_o       = busy ? feed_byte[gidx_q] : 8'h00;
  assign bus.valid_o      = sel_valid;
  assign bus.feed_ready_o = grant_q & {NUM_FEEDS{bus.ready_i}};
  assign bus.grant_o      = grant_q;
  assign bus.busy_o       = busy;
  assign bus.msg_done_o   = msg_done_q;
  assign bus.len_err_o    = len_err_q;
  assign bus.msg_count_o  = msg_count_q;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner's offset.
  assign req_rot = NUM_FEEDS'({bus.feed_valid_i, bus.feed_valid_i} >> rr_ptr_q);

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = NUM_FEEDS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_found = 1'b1;
        pick_off   = (IDX_W+1)'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + pick_off;
    pick_idx = (pick_sum >= (IDX_W+1)'(NUM_FEEDS)) ?
               IDX_W'(pick_sum - (IDX_W+1)'(NUM_FEEDS)) : IDX_W'(pick_sum);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    len_hi_d    = len_hi_q;
    remaining_d = remaining_q;
    msg_count_d = msg_count_q;
    msg_done_d  = 1'b0;
    len_err_d   = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          grant_d = NUM_FEEDS'(1) << pick_idx;
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (hs) begin
          len_hi_d = feed_byte[gidx_q];
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (hs) begin
          len_err_d = (len_full > MAX_LEN);
          if (len_full == 16'd0) begin
            done = 1'b1;
          end else begin
            remaining_d = len_full;
            state_d     = BODY;
          end
        end
      end
      BODY: begin
        if (hs) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d     = IDLE;
      grant_d     = '0;
      msg_done_d  = 1'b1;
      msg_count_d = msg_count_q + CNT_W'(1);
      rr_ptr_d    = (gidx_q == IDX_W'(NUM_FEEDS - 1)) ? '0 : gidx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      len_hi_q    <= '0;
      remaining_q <= '0;
      msg_count_q <= '0;
      msg_done_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      len_hi_q    <= len_hi_d;
      remaining_q <= remaining_d;
      msg_count_q <= msg_count_d;
      msg_done_q  <= msg_done_d;
      len_err_q   <= len_err_d;
    end
  end
endmodule

// File: tb/tb_itch_feed_arbiter.sv
// Bench for itch_feed_arbiter: a table of message scenarios, directed reset-mid-message
// sequence, and randomized traffic checked against a message-level round-robin model.
module tb_itch_feed_arbiter;
  localparam int NF   = 2;
  localparam int MAXL = 64;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  itch_feed_arbiter_if #(.NUM_FEEDS(NF), .CNT_W(CW)) bus ();

  itch_feed_arbiter #(.NUM_FEEDS(NF), .MAX_MSG_LEN(MAXL), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int len0;      // -1: feed 0 sends nothing
    int len1;      // -1: feed 1 sends nothing
    int stall_at;  // handshake index at which ready_i drops (-1: none)
    int stall_n;
    int drop_at;   // feed 0 byte index at which its valid drops (-1: none)
    int drop_n;
    int exp_bytes;
    int exp_errs;
    int exp_msgs;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Source side: per-feed byte queues and message lengths still to send.
  logic [7:0] fq   [NF][$];
  int         mlen [NF][$];
  int         fpos [NF];

  // Reference model state: which feed's message should be on the parser port.
  int exp_feed, exp_idx, exp_tot, exp_len, m_ptr, m_count;
  int dut_bytes, errs_seen;
  int ready_pct, drop_pct, stall_at, stall_n, stall_cnt, drop_at, drop_n, drop_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_msg(input int f, input int len, input logic [7:0] typ);
    fq[f].push_back(8'(len >> 8));
    fq[f].push_back(8'(len));
    for (int i = 0; i < len; i++) fq[f].push_back(i == 0 ? typ : 8'($urandom));
    mlen[f].push_back(len);
  endtask

  function automatic bit pending();
    for (int f = 0; f < NF; f++) if (mlen[f].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int f = 0; f < NF; f++) begin
      fq[f].delete();
      mlen[f].delete();
      fpos[f] = 0;
    end
    exp_feed = -1; exp_idx = 0; exp_tot = 0; exp_len = 0; m_ptr = 0; m_count = 0;
    dut_bytes = 0; errs_seen = 0;
    ready_pct = 100; drop_pct = 0;
    stall_at = -1; stall_n = 0; stall_cnt = 0;
    drop_at = -1; drop_n = 0; drop_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.ready_i = 1'b0;
    bus.feed_valid_i = '0;
    bus.feed_data_i = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: drive at negedge, check combinational path, then check registered outputs.
  task automatic step();
    logic [NF-1:0] v;
    logic [NF-1:0] oh;
    bit hs, last, err_exp;
    int pick;
    @(negedge clk);
    if (stall_at >= 0 && exp_feed >= 0 && exp_idx == stall_at) begin
      stall_cnt = stall_n;
      stall_at  = -1;
    end
    if (drop_at >= 0 && fpos[0] == drop_at) begin
      drop_cnt = drop_n;
      drop_at  = -1;
    end
    if (stall_cnt > 0) begin
      bus.ready_i = 1'b0;
      stall_cnt--;
    end else begin
      bus.ready_i = ($urandom_range(99) < ready_pct);
    end
    v = '0;
    for (int f = 0; f < NF; f++) begin
      v[f] = (fq[f].size() > 0);
      // Sources only pause mid-message, so every pending feed requests at IDLE.
      if (fpos[f] > 0 && $urandom_range(99) < drop_pct) v[f] = 1'b0;
      bus.feed_data_i[f*8 +: 8] = v[f] ? fq[f][0] : 8'($urandom);
    end
    if (drop_cnt > 0) begin
      v[0] = 1'b0;
      drop_cnt--;
    end
    bus.feed_valid_i = v;
    #1;
    hs = 1'b0; last = 1'b0; err_exp = 1'b0;
    if (bus.valid_o && bus.ready_i) dut_bytes++;
    if (exp_feed < 0) begin
      chk("idle_busy", bus.busy_o, 0);
      chk("idle_valid", bus.valid_o, 0);
      chk("idle_feed_ready", bus.feed_ready_o, 0);
      chk("idle_data", bus.data_o, 0);
      chk("idle_grant", bus.grant_o, 0);
      if (pending()) begin
        pick = -1;
        for (int k = NF - 1; k >= 0; k--)
          if (mlen[(m_ptr + k) % NF].size() > 0) pick = (m_ptr + k) % NF;
        exp_feed = pick;
        exp_idx  = 0;
        exp_len  = mlen[pick][0];
        exp_tot  = exp_len + 2;
      end
    end else begin
      oh = NF'(1) << exp_feed;
      chk("grant", bus.grant_o, oh);
      chk("busy", bus.busy_o, 1);
      chk("feed_ready", bus.feed_ready_o, bus.ready_i ? oh : '0);
      chk("valid_o", bus.valid_o, v[exp_feed]);
      if (v[exp_feed]) chk("data_o", bus.data_o, fq[exp_feed][0]);
      if (v[exp_feed] && bus.ready_i) begin
        hs = 1'b1;
        void'(fq[exp_feed].pop_front());
        exp_idx++;
        fpos[exp_feed]++;
        err_exp = (exp_idx == 2) && (exp_len > MAXL);
        last    = (exp_idx == exp_tot);
      end
    end
    @(posedge clk);
    #1;
    chk("msg_done", bus.msg_done_o, last);
    chk("len_err", bus.len_err_o, hs && err_exp);
    if (bus.len_err_o) errs_seen++;
    if (last) begin
      m_count++;
      chk("msg_count", bus.msg_count_o, m_count);
      $display("[TB] message feed=%0d len=%0d bytes=%0d count=%0d", exp_feed, exp_len, exp_tot, m_count);
      void'(mlen[exp_feed].pop_front());
      fpos[exp_feed] = 0;
      m_ptr    = (exp_feed + 1) % NF;
      exp_feed = -1;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int cyc = 0;
    while (pending() && cyc < budget) begin
      step();
      cyc++;
    end
    chk("drain_timeout", pending(), 0);
  endtask

  vec_t vecs[11];
  int   rand_errs;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{36, -1, -1, 0, -1, 0,  38, 0, 1};  // add-order, feed 0 alone
    vecs[1]  = '{19, 40, -1, 0, -1, 0,  63, 0, 2};  // simultaneous requests
    vecs[2]  = '{36, -1, 12, 5, -1, 0,  38, 0, 1};  // 5-cycle stall at body byte 10
    vecs[3]  = '{36, 10, -1, 0, 20, 8,  50, 0, 2};  // feed 0 drops valid, feed 1 waits
    vecs[4]  = '{ 0, -1, -1, 0, -1, 0,   2, 0, 1};  // zero-length message
    vecs[5]  = '{80, -1, -1, 0, -1, 0,  82, 1, 1};  // oversize length
    vecs[6]  = '{64, -1, -1, 0, -1, 0,  66, 0, 1};  // exactly MAX_MSG_LEN
    vecs[7]  = '{65, -1, -1, 0, -1, 0,  67, 1, 1};  // one above MAX_MSG_LEN
    vecs[8]  = '{-1,  5, -1, 0, -1, 0,   7, 0, 1};  // feed 1 alone
    vecs[9]  = '{256, -1, -1, 0, -1, 0, 258, 1, 1}; // nonzero high length byte
    vecs[10] = '{ 0,  0, -1, 0, -1, 0,   4, 0, 2};  // back-to-back empty messages

    reset_n = 1'b0;
    bus.ready_i = 1'b0;
    bus.feed_valid_i = '0;
    bus.feed_data_i = '0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_grant", bus.grant_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_count", bus.msg_count_o, 0);
    chk("reset_done", bus.msg_done_o, 0);
    chk("reset_len_err", bus.len_err_o, 0);
    chk("reset_valid", bus.valid_o, 0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      stall_at = vecs[i].stall_at;
      stall_n  = vecs[i].stall_n;
      drop_at  = vecs[i].drop_at;
      drop_n   = vecs[i].drop_n;
      if (vecs[i].len0 >= 0) load_msg(0, vecs[i].len0, 8'h41);
      if (vecs[i].len1 >= 0) load_msg(1, vecs[i].len1, 8'h44);
      run_until_idle(2000);
      chk("vec_bytes", dut_bytes, vecs[i].exp_bytes);
      chk("vec_msgs", bus.msg_count_o, vecs[i].exp_msgs);
      chk("vec_len_errs", errs_seen, vecs[i].exp_errs);
    end

    // Reset asserted in the middle of a message body.
    do_reset();
    load_msg(0, 36, 8'h41);
    run_until_idle(500);
    load_msg(0, 36, 8'h41);
    for (int c = 0; c < 200 && !(exp_feed >= 0 && exp_idx >= 22); c++) step();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_grant", bus.grant_o, 0);
    chk("midreset_busy", bus.busy_o, 0);
    chk("midreset_count", bus.msg_count_o, 0);
    chk("midreset_feed_ready", bus.feed_ready_o, 0);
    chk("midreset_valid", bus.valid_o, 0);
    model_clear();
    bus.feed_valid_i = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    load_msg(0, 36, 8'h41);
    run_until_idle(500);
    chk("postreset_bytes", dut_bytes, 38);
    chk("postreset_count", bus.msg_count_o, 1);

    // Randomized traffic with backpressure and mid-message valid gaps.
    do_reset();
    ready_pct = 70;
    drop_pct  = 25;
    rand_errs = 0;
    for (int m = 0; m < 40; m++) begin
      int f, len;
      f   = int'($urandom_range(NF - 1));
      len = int'($urandom_range(90));
      if (len > MAXL) rand_errs++;
      load_msg(f, len, 8'h41 + 8'(f));
    end
    run_until_idle(30000);
    chk("rand_msgs", bus.msg_count_o, 40);
    chk("rand_len_errs", errs_seen, rand_errs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
